// File: rtl/mc_ctrl.sv
// Multicycle control FSM for a MIPS-subset datapath: sequences fetch, decode and
// per-class execution states and drives ALU, mux selects and write enables.
module mc_ctrl #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    input  logic            zero,
    input  logic            overflow,
    output logic [3:0]      alu_op,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      ext_op,
    output logic            pc_wr,
    output logic [1:0]      pc_src,
    output logic            ir_wr,
    output logic            mem_wr,
    output logic            reg_wr,
    output logic [1:0]      reg_dst,
    output logic [1:0]      wb_src,
    output logic [ST_W-1:0] state
);

    typedef enum logic [ST_W-1:0] {
        FETCH  = ST_W'(0),
        DECODE = ST_W'(1),
        MADR   = ST_W'(2),
        MRD    = ST_W'(3),
        MWR    = ST_W'(4),
        MWB    = ST_W'(5),
        EXE    = ST_W'(6),
        RWB    = ST_W'(7),
        BR     = ST_W'(8),
        JMP    = ST_W'(9)
    } state_e;

    localparam logic [3:0] ALU_ADDU  = 4'd0;
    localparam logic [3:0] ALU_SUBU  = 4'd1;
    localparam logic [3:0] ALU_OR    = 4'd2;
    localparam logic [3:0] ALU_PASSB = 4'd3;
    localparam logic [3:0] ALU_ADD   = 4'd5;
    localparam logic [3:0] ALU_LT    = 4'd6;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_e     state_q, state_d;
    logic       ov_flag_q, ov_flag_d;

    logic [3:0] alu_op_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] ext_op_s;
    logic       pc_wr_s;
    logic [1:0] pc_src_s;
    logic       ir_wr_s;
    logic       mem_wr_s;
    logic       reg_wr_s;
    logic [1:0] reg_dst_s;
    logic [1:0] wb_src_s;

    // Next-state and output decode from the current state and instruction fields
    always_comb begin
        alu_op_s    = ALU_ADDU;
        alu_src_a_s = 1'b0;
        alu_src_b_s = 2'd0;
        ext_op_s    = 2'd0;
        pc_wr_s     = 1'b0;
        pc_src_s    = 2'd0;
        ir_wr_s     = 1'b0;
        mem_wr_s    = 1'b0;
        reg_wr_s    = 1'b0;
        reg_dst_s   = 2'd0;
        wb_src_s    = 2'd0;
        state_d     = FETCH;
        ov_flag_d   = ov_flag_q;
        case (state_q)
            FETCH: begin
                ir_wr_s     = 1'b1;
                alu_src_b_s = 2'd1;
                pc_wr_s     = 1'b1;
                ov_flag_d   = 1'b0;
                state_d     = DECODE;
            end
            DECODE: begin
                // Branch target is precomputed here so BR only needs the compare
                alu_src_b_s = 2'd3;
                ext_op_s    = 2'd1;
                case (op)
                    OP_LW, OP_SW:                      state_d = MADR;
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADDU, FN_SUBU, FN_SLT:  state_d = EXE;
                            FN_JR:                     state_d = JMP;
                            default:                   state_d = FETCH;
                        endcase
                    end
                    OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: state_d = EXE;
                    OP_BEQ:                            state_d = BR;
                    OP_J, OP_JAL:                      state_d = JMP;
                    default:                           state_d = FETCH;
                endcase
            end
            MADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'd2;
                ext_op_s    = 2'd1;
                if (op == OP_LW) begin
                    state_d = MRD;
                end else begin
                    state_d = MWR;
                end
            end
            MRD: state_d = MWB;
            MWR: mem_wr_s = 1'b1;
            MWB: begin
                reg_wr_s = 1'b1;
                wb_src_s = 2'd1;
            end
            EXE: begin
                alu_src_a_s = 1'b1;
                ov_flag_d   = overflow;
                state_d     = RWB;
                case (op)
                    OP_RTYPE: begin
                        case (funct)
                            FN_SUBU: alu_op_s = ALU_SUBU;
                            FN_SLT:  alu_op_s = ALU_LT;
                            default: alu_op_s = ALU_ADDU;
                        endcase
                    end
                    OP_ADDI: begin
                        alu_src_b_s = 2'd2;
                        ext_op_s    = 2'd1;
                        alu_op_s    = ALU_ADD;
                    end
                    OP_ADDIU: begin
                        alu_src_b_s = 2'd2;
                        ext_op_s    = 2'd1;
                    end
                    OP_ORI: begin
                        alu_src_b_s = 2'd2;
                        alu_op_s    = ALU_OR;
                    end
                    OP_LUI: begin
                        alu_src_a_s = 1'b0;
                        alu_src_b_s = 2'd2;
                        ext_op_s    = 2'd2;
                        alu_op_s    = ALU_PASSB;
                    end
                    default: alu_op_s = ALU_ADDU;
                endcase
            end
            RWB: begin
                reg_wr_s  = ~ov_flag_q;
                reg_dst_s = (op == OP_RTYPE) ? 2'd1 : 2'd0;
            end
            BR: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = ALU_SUBU;
                pc_src_s    = 2'd1;
                pc_wr_s     = zero;
            end
            JMP: begin
                pc_wr_s  = 1'b1;
                // Only jr reaches JMP with an R-type opcode
                pc_src_s = (op == OP_RTYPE) ? 2'd3 : 2'd2;
                if (op == OP_JAL) begin
                    reg_wr_s  = 1'b1;
                    reg_dst_s = 2'd2;
                    wb_src_s  = 2'd2;
                end else begin
                    reg_wr_s  = 1'b0;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // State and overflow-latch registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            ov_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ov_flag_q <= ov_flag_d;
        end
    end

    assign alu_op    = alu_op_s;
    assign alu_src_a = alu_src_a_s;
    assign alu_src_b = alu_src_b_s;
    assign ext_op    = ext_op_s;
    assign pc_src    = pc_src_s;
    assign reg_dst   = reg_dst_s;
    assign wb_src    = wb_src_s;
    assign pc_wr     = pc_wr_s  & rst_n;
    assign ir_wr     = ir_wr_s  & rst_n;
    assign mem_wr    = mem_wr_s & rst_n;
    assign reg_wr    = reg_wr_s & rst_n;
    assign state     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class state by state and
// compares the decoded controls against hand-computed values.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       overflow = 1'b0;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ext_op;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       ir_wr;
    logic       mem_wr;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic [3:0] state;

    int n_vec = 0;
    int n_err = 0;

    mc_ctrl #(.ST_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .overflow(overflow), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_op(ext_op), .pc_wr(pc_wr), .pc_src(pc_src),
        .ir_wr(ir_wr), .mem_wr(mem_wr), .reg_wr(reg_wr), .reg_dst(reg_dst),
        .wb_src(wb_src), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd0};
        logic       exp_mw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rst_n = 1'b0; op = 6'b101011; funct = 6'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({state, pc_wr, ir_wr, mem_wr, reg_wr} !== 8'h00) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: state/pc/ir/mem/reg=%h, want 00", i,
                         {state, pc_wr, ir_wr, mem_wr, reg_wr});
            end
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if ({pc_wr, ir_wr, alu_src_b} !== 4'b1101) begin
            n_err++;
            $display("FAIL fetch_ctl: pc_wr/ir_wr/src_b=%b, want 1101", {pc_wr, ir_wr, alu_src_b});
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_vec++;
            if ({state, mem_wr} !== {exp_st[i], exp_mw[i]}) begin
                n_err++;
                $display("FAIL sw_seq[%0d]: state=%0d mem_wr=%b, want state=%0d mem_wr=%b",
                         i, state, mem_wr, exp_st[i], exp_mw[i]);
            end
        end
    endtask

    task automatic test_exe_ops;
        // op, funct, alu_op, src_a, src_b, ext_op, reg_dst
        logic [5:0] t_op [6] = '{6'b000000, 6'b000000, 6'b000000, 6'b001001, 6'b001101, 6'b001111};
        logic [5:0] t_fn [6] = '{6'b100001, 6'b100011, 6'b101010, 6'd0, 6'd0, 6'd0};
        logic [3:0] t_alu[6] = '{4'd0, 4'd1, 4'd6, 4'd0, 4'd2, 4'd3};
        logic       t_sa [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] t_sb [6] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2};
        logic [1:0] t_ext[6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2};
        logic [1:0] t_rd [6] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
        for (int k = 0; k < 6; k++) begin
            op = t_op[k]; funct = t_fn[k];
            tick();
            n_vec++;
            if ({state, alu_op, alu_src_a, alu_src_b, ext_op} !== {4'd1, 4'd0, 1'b0, 2'd3, 2'd1}) begin
                n_err++;
                $display("FAIL decode[%0d]: st/alu/sa/sb/ext=%h, want %h", k,
                         {state, alu_op, alu_src_a, alu_src_b, ext_op}, {4'd1, 4'd0, 1'b0, 2'd3, 2'd1});
            end
            tick();
            n_vec++;
            if ({state, alu_op, alu_src_a, alu_src_b, ext_op} !== {4'd6, t_alu[k], t_sa[k], t_sb[k], t_ext[k]}) begin
                n_err++;
                $display("FAIL exe[%0d]: st/alu/sa/sb/ext=%h, want %h", k,
                         {state, alu_op, alu_src_a, alu_src_b, ext_op}, {4'd6, t_alu[k], t_sa[k], t_sb[k], t_ext[k]});
            end
            tick();
            n_vec++;
            if ({state, reg_wr, reg_dst, wb_src, pc_wr} !== {4'd7, 1'b1, t_rd[k], 2'd0, 1'b0}) begin
                n_err++;
                $display("FAIL rwb[%0d]: st/rw/rd/wb/pc=%h, want %h", k,
                         {state, reg_wr, reg_dst, wb_src, pc_wr}, {4'd7, 1'b1, t_rd[k], 2'd0, 1'b0});
            end
            tick();
            n_vec++;
            if (state !== 4'd0) begin
                n_err++;
                $display("FAIL exe_ret[%0d]: state=%0d, want 0", k, state);
            end
        end
    endtask

    task automatic test_addi_overflow;
        for (int v = 1; v >= 0; v--) begin
            op = 6'b001000; funct = 6'd0;
            tick();
            tick();
            overflow = v[0];
            #1;
            n_vec++;
            if ({state, alu_op, alu_src_a, alu_src_b, ext_op} !== {4'd6, 4'd5, 1'b1, 2'd2, 2'd1}) begin
                n_err++;
                $display("FAIL addi_exe(ov=%0d): st/alu/sa/sb/ext=%h, want %h", v,
                         {state, alu_op, alu_src_a, alu_src_b, ext_op}, {4'd6, 4'd5, 1'b1, 2'd2, 2'd1});
            end
            tick();
            overflow = 1'b0;
            #1;
            n_vec++;
            if ({state, reg_wr, reg_dst} !== {4'd7, ~v[0], 2'd0}) begin
                n_err++;
                $display("FAIL addi_rwb(ov=%0d): st/rw/rd=%h, want %h", v,
                         {state, reg_wr, reg_dst}, {4'd7, ~v[0], 2'd0});
            end
            tick();
        end
    endtask

    task automatic test_beq;
        for (int z = 1; z >= 0; z--) begin
            op = 6'b000100; funct = 6'd0;
            tick();
            tick();
            zero = z[0];
            #1;
            n_vec++;
            if ({state, pc_wr, pc_src, alu_op, alu_src_a, alu_src_b} !== {4'd8, z[0], 2'd1, 4'd1, 1'b1, 2'd0}) begin
                n_err++;
                $display("FAIL beq(z=%0d): st/pc/src/alu/sa/sb=%h, want %h", z,
                         {state, pc_wr, pc_src, alu_op, alu_src_a, alu_src_b}, {4'd8, z[0], 2'd1, 4'd1, 1'b1, 2'd0});
            end
            zero = 1'b0;
            tick();
            n_vec++;
            if (state !== 4'd0) begin
                n_err++;
                $display("FAIL beq_ret(z=%0d): state=%0d, want 0", z, state);
            end
        end
    endtask

    task automatic test_jumps;
        // jal, jr, j
        logic [5:0] t_op [3] = '{6'b000011, 6'b000000, 6'b000010};
        logic [5:0] t_fn [3] = '{6'd0, 6'b001000, 6'd0};
        logic [7:0] t_exp[3] = '{{1'b1, 2'd2, 1'b1, 2'd2, 2'd2}, {1'b1, 2'd3, 1'b0, 2'd0, 2'd0},
                                 {1'b1, 2'd2, 1'b0, 2'd0, 2'd0}};
        for (int k = 0; k < 3; k++) begin
            op = t_op[k]; funct = t_fn[k];
            tick();
            tick();
            n_vec++;
            if ({state, pc_wr, pc_src, reg_wr, reg_dst, wb_src} !== {4'd9, t_exp[k]}) begin
                n_err++;
                $display("FAIL jmp[%0d]: st/pc/src/rw/rd/wb=%h, want %h", k,
                         {state, pc_wr, pc_src, reg_wr, reg_dst, wb_src}, {4'd9, t_exp[k]});
            end
            tick();
            n_vec++;
            if (state !== 4'd0) begin
                n_err++;
                $display("FAIL jmp_ret[%0d]: state=%0d, want 0", k, state);
            end
        end
    endtask

    task automatic test_nop_lw;
        logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd0};
        op = 6'b111111; funct = 6'd0;
        tick();
        n_vec++;
        if ({state, pc_wr, ir_wr, mem_wr, reg_wr} !== {4'd1, 4'b0000}) begin
            n_err++;
            $display("FAIL nop_dec: st/pc/ir/mem/reg=%h, want 10", {state, pc_wr, ir_wr, mem_wr, reg_wr});
        end
        tick();
        n_vec++;
        if (state !== 4'd0) begin
            n_err++;
            $display("FAIL nop_ret: state=%0d, want 0", state);
        end
        op = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            n_vec++;
            if (state !== exp_st[i]) begin
                n_err++;
                $display("FAIL lw_seq[%0d]: state=%0d, want %0d", i, state, exp_st[i]);
            end
            if (i == 2) begin
                n_vec++;
                if ({alu_src_a, alu_src_b, ext_op, alu_op} !== {1'b1, 2'd2, 2'd1, 4'd0}) begin
                    n_err++;
                    $display("FAIL lw_madr: sa/sb/ext/alu=%h, want %h",
                             {alu_src_a, alu_src_b, ext_op, alu_op}, {1'b1, 2'd2, 2'd1, 4'd0});
                end
            end
            if (i == 4) begin
                n_vec++;
                if ({reg_wr, reg_dst, wb_src, mem_wr} !== {1'b1, 2'd0, 2'd1, 1'b0}) begin
                    n_err++;
                    $display("FAIL lw_mwb: rw/rd/wb/mw=%h, want %h",
                             {reg_wr, reg_dst, wb_src, mem_wr}, {1'b1, 2'd0, 2'd1, 1'b0});
                end
            end
        end
    endtask

    task automatic test_mid_reset;
        op = 6'b101011;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({state, mem_wr, pc_wr, ir_wr, reg_wr} !== {4'd4, 4'b0000}) begin
            n_err++;
            $display("FAIL mid_reset_gate: st/mem/pc/ir/reg=%h, want 40", {state, mem_wr, pc_wr, ir_wr, reg_wr});
        end
        tick();
        n_vec++;
        if ({state, mem_wr, pc_wr, ir_wr, reg_wr} !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset_state: st/mem/pc/ir/reg=%h, want 00", {state, mem_wr, pc_wr, ir_wr, reg_wr});
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if ({state, ir_wr, pc_wr} !== {4'd0, 2'b11}) begin
            n_err++;
            $display("FAIL mid_reset_release: st/ir/pc=%h, want 03", {state, ir_wr, pc_wr});
        end
    endtask

    initial begin
        test_reset();
        test_exe_ops();
        test_addi_overflow();
        test_beq();
        test_jumps();
        test_nop_lw();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM that sits directly upstream of the ALU and drives its 4-bit operation code and operand-select muxes every cycle.
- Also sequences PC, IR, memory and register-file writes, using the ALU's zero and overflow flags.
- Sequences one instruction at a time: Fetch, Decode, then per-class states, then back to Fetch.

Parameters:
- ST_W, 4, width of the state register (debug port width).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- op  in  6  IR[31:26], held stable by the IR after FETCH.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, combinational from the ALU.
- overflow  in  1  ALU signed-overflow flag, combinational.
- alu_op  out  4  ALU operation. Codes: 0 Addu, 1 Subu, 2 Or, 3 PassB, 4 PassA, 5 Add (signed, flags overflow), 6 Lt (signed).
- alu_src_a  out  1  0 = PC, 1 = A register.
- alu_src_b  out  2  0 = B register, 1 = constant 4, 2 = extended imm, 3 = extended imm<<2.
- ext_op  out  2  0 = zero-extend, 1 = sign-extend, 2 = imm<<16.
- pc_wr  out  1  PC write enable.
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = {PC[31:28], target, 2'b00}, 3 = A register.
- ir_wr  out  1  IR write enable.
- mem_wr  out  1  data-memory write enable.
- reg_wr  out  1  register-file write enable.
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $31.
- wb_src  out  2  0 = ALUOut, 1 = MDR, 2 = PC.
- state  out  ST_W  current state (debug).

Behaviour:
- State encodings: FETCH=0, DECODE=1, MADR=2, MRD=3, MWR=4, MWB=5, EXE=6, RWB=7, BR=8, JMP=9. Codes 10-15 go to FETCH on the next cycle with all enables 0.
- Outputs are decoded from state (plus op/funct/zero/ov_flag). Any output not listed for a state is 0.
- Reset: while rst_n=0, pc_wr, ir_wr, mem_wr and reg_wr are forced to 0, and state loads FETCH at the clock edge. The first cycle after rst_n rises is FETCH. Reset asserted mid-instruction aborts it; nothing further is written.
- FETCH:
  - Outputs: ir_wr=1, alu_src_a=0, alu_src_b=1, alu_op=Addu, pc_src=0, pc_wr=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, ext_op=1, alu_op=Addu. This computes the branch target into ALUOut.
  - lw (100011), sw (101011) -> MADR.
  - R-type (000000) with funct addu 100001, subu 100011 or slt 101010 -> EXE. R-type with funct jr 001000 -> JMP.
  - addi 001000, addiu 001001, ori 001101, lui 001111 -> EXE.
  - beq 000100 -> BR. j 000010, jal 000011 -> JMP.
  - Any other op/funct -> FETCH (treated as a nop).
- MADR:
  - Outputs: alu_src_a=1, alu_src_b=2, ext_op=1, alu_op=Addu.
  - Next state: lw -> MRD, sw -> MWR.
- MRD: next state MWB.
- MWR: mem_wr=1; next state FETCH.
- MWB: reg_wr=1, reg_dst=0, wb_src=1; next state FETCH.
- EXE (next state RWB):
  - addu: alu_src_a=1, alu_src_b=0, alu_op=Addu.
  - subu: alu_src_a=1, alu_src_b=0, alu_op=Subu.
  - slt: alu_src_a=1, alu_src_b=0, alu_op=Lt.
  - addi: alu_src_a=1, alu_src_b=2, ext_op=1, alu_op=Add.
  - addiu: alu_src_a=1, alu_src_b=2, ext_op=1, alu_op=Addu.
  - ori: alu_src_a=1, alu_src_b=2, ext_op=0, alu_op=Or.
  - lui: alu_src_b=2, ext_op=2, alu_op=PassB.
  - Overflow latch: an internal ov_flag register captures overflow at the end of EXE. It is cleared in FETCH and by reset.
- RWB:
  - Outputs: wb_src=0; reg_dst=1 for R-type, 0 otherwise.
  - reg_wr=1 unless ov_flag=1. An addi that overflows writes nothing.
  - Next state: FETCH.
- BR:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=Subu, pc_src=1.
  - pc_wr=zero (combinational, same cycle).
  - Next state: FETCH.
- JMP:
  - pc_wr=1. pc_src=3 for jr, otherwise 2.
  - jal: additionally reg_wr=1, reg_dst=2, wb_src=2. PC already holds PC+4 from FETCH.
  - Next state: FETCH.
- Cycle counts:
  - lw: 5.
  - sw, R-type and I-type ALU: 4.
  - beq, j, jal, jr: 3.
  - Unsupported opcode: 2.

Test Plan:
- rst_n=0 held for 3 cycles while op=sw -> state=0 and mem_wr=pc_wr=reg_wr=ir_wr=0 throughout. After release, the state sequence is 0,1,2,4,0 and mem_wr=1 only in state 4.
- addu (op=0, funct=100001) -> states 0,1,6,7,0. alu_op=0 with alu_src_b=0 in EXE; reg_wr=1, reg_dst=1 in RWB.
- addi with overflow=1 driven during EXE -> alu_op=5 in EXE and reg_wr=0 in RWB. Repeating with overflow=0 gives reg_wr=1, reg_dst=0.
- beq with zero=1 -> pc_wr=1, pc_src=1, alu_op=1 in BR. beq with zero=0 -> pc_wr=0. Both return to FETCH after 3 cycles.
- jal -> JMP with pc_wr=1, pc_src=2, reg_wr=1, reg_dst=2, wb_src=2. jr (op=0, funct=001000) -> pc_src=3, reg_wr=0.
- op=111111 -> states 0,1,0 with no write enable asserted after FETCH. lw -> states 0,1,2,3,5 with reg_wr=1, wb_src=1 in MWB.
